// File: rtl/router_in_port_if.sv
// Flit/credit link and switch-allocator handshake bundle for one router input port.
// The master side is the upstream link plus allocator; the slave side is router_in_port.
interface router_in_port_if #(
  parameter int FLIT_W = 32
);
  logic [FLIT_W-1:0] i_flit;
  logic              i_flit_valid;
  logic              o_credit;
  logic [4:0]        o_req;
  logic              i_grant;
  logic              i_out_rdy;
  logic [FLIT_W-1:0] o_flit;
  logic              o_flit_valid;

  modport master (
    output i_flit, i_flit_valid, i_grant, i_out_rdy,
    input  o_credit, o_req, o_flit, o_flit_valid
  );

  modport slave (
    input  i_flit, i_flit_valid, i_grant, i_out_rdy,
    output o_credit, o_req, o_flit, o_flit_valid
  );
endinterface

// File: rtl/router_in_port.sv
// Router input port: DEPTH-entry flit FIFO with credit return, XY route decode of
// head flits and a held one-hot output request until the packet tail is forwarded.
module router_in_port #(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  router_in_port_if.slave        bus,
  input  logic [COORD_W-1:0]     local_x,
  input  logic [COORD_W-1:0]     local_y,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic [1:0]             o_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     occ;
  logic [FLIT_W-1:0] head;
  logic [1:0]        head_type;
  logic              empty, full;
  logic              xfer, discard, pop, push_ok;
  logic              head_is_tail, head_opens;

  function automatic logic [4:0] xy_route(
    input logic [COORD_W-1:0] dx, dy, lx, ly
  );
    if (dx > lx)      return 5'b00010;
    else if (dx < lx) return 5'b00100;
    else if (dy > ly) return 5'b01000;
    else if (dy < ly) return 5'b10000;
    else              return 5'b00001;
  endfunction

  assign head         = mem[rd_ptr];
  assign head_type    = head[FLIT_W-1:FLIT_W-2];
  assign empty        = (occ == '0);
  assign full         = (occ == FULL_CNT);
  assign head_is_tail = (head_type == T_TAIL) || (head_type == T_SINGLE);
  assign head_opens   = (head_type == T_HEAD) || (head_type == T_SINGLE);

  assign xfer    = (state == ACTIVE) && bus.i_grant && bus.i_out_rdy && !empty;
  assign discard = (state == IDLE) && !empty &&
                   ((head_type == T_BODY) || (head_type == T_TAIL));
  assign pop     = xfer || discard;
  // A full FIFO still accepts a push when a slot frees in the same cycle.
  assign push_ok = bus.i_flit_valid && (!full || pop);

  assign bus.o_flit       = head;
  assign bus.o_flit_valid = xfer;
  assign o_occupancy      = occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.i_flit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Head flits are routed but left in the FIFO; they leave through the ACTIVE path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus.o_req <= '0;
    end else begin
      case (state)
        IDLE: if (!empty && head_opens) begin
          bus.o_req <= xy_route(head[2*COORD_W-1:COORD_W], head[COORD_W-1:0],
                                local_x, local_y);
          state     <= ACTIVE;
        end
        ACTIVE: if (xfer && head_is_tail) begin
          bus.o_req <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_credit <= 1'b0;
      o_err        <= '0;
    end else begin
      bus.o_credit <= pop;
      if (bus.i_flit_valid && full && !pop) o_err[0] <= 1'b1;
      if (discard)                          o_err[1] <= 1'b1;
    end
  end
endmodule
